alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_core.sv | 58 +++++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_CMP   = 3'b001;
  localparam logic [2:0] OP_PASSB = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_NAND  = 3'b100;
  localparam logic [2:0] OP_ADC   = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU datapath: logic ops plus (WIDTH+1)-bit
// arithmetic with carry/borrow and zero flags. Multiply is not handled here.
import alu_pkg::*;

module alu_core #(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       cmd_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o,
  output logic             zero_o
);

  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] sum;
  logic           arith;

  // Select the operation; arithmetic ops derive result and both flags from
  // the extended sum, all other ops leave both flags forced low.
  always_comb begin
    ext_a  = {1'b0, a_i};
    ext_b  = {1'b0, b_i};
    sum    = '0;
    arith  = 1'b0;
    res_o  = '0;
    cout_o = 1'b0;
    zero_o = 1'b0;
    case (cmd_i)
      OP_PASSA: res_o = a_i;
      OP_CMP: begin
        sum   = ext_a - ext_b;
        arith = 1'b1;
      end
      OP_PASSB: res_o = b_i;
      OP_ADD: begin
        sum   = ext_a + ext_b;
        arith = 1'b1;
      end
      OP_NAND: res_o = ~(a_i & b_i);
      OP_ADC: begin
        sum   = ext_a + ext_b + {{WIDTH{1'b0}}, cin_i};
        arith = 1'b1;
      end
      OP_XOR: res_o = a_i ^ b_i;
      default: res_o = '0;
    endcase
    if (arith) begin
      res_o  = sum[WIDTH-1:0];
      cout_o = sum[WIDTH];
      zero_o = (sum == '0);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete in one cycle through alu_core;
// unsigned multiply runs as a WIDTH-step shift-add while in_ready is low.
import alu_pkg::*;

module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             out_valid
);

  localparam int         PW        = 2 * WIDTH;
  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             accept;
  logic             mul_last;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [5:0]       step_q, step_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] core_res;
  logic             core_cout;
  logic             core_zero;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .cmd_i  (command),
    .a_i    (A),
    .b_i    (B),
    .cin_i  (carry_q),
    .res_o  (core_res),
    .cout_o (core_cout),
    .zero_o (core_zero)
  );

  assign accept   = in_valid && in_ready;
  assign mul_last = (state_q == ST_MUL) && (step_q == LAST_STEP);
  // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: enter MUL on an accepted multiply, leave after the last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && command == OP_MUL) state_d = ST_MUL;
      ST_MUL:  if (step_q == LAST_STEP)         state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: commands are only taken while idle.
  always_comb begin
    in_ready = (state_q == ST_IDLE);
  end

  // Multiplier next state: load operands on accept, shift one step per MUL cycle.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    step_d   = step_q;
    if (state_q == ST_MUL) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_sum;
      step_d   = step_q + 6'd1;
    end else if (accept && command == OP_MUL) begin
      mcand_d  = {{WIDTH{1'b0}}, A};
      mplier_d = B;
      acc_d    = '0;
      step_d   = '0;
    end
  end

  // Multiplier registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      step_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
    end
  end

  // Output next state: load on a completion, otherwise hold and drop out_valid.
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    vld_d    = 1'b0;
    if (mul_last) begin
      result_d = acc_sum[WIDTH-1:0];
      carry_d  = |acc_sum[PW-1:WIDTH];
      zero_d   = (acc_sum == '0);
      vld_d    = 1'b1;
    end else if (accept && command != OP_MUL) begin
      result_d = core_res;
      carry_d  = core_cout;
      zero_d   = core_zero;
      vld_d    = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      vld_q    <= vld_d;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=4): directed cases plus randomized commands
// compared against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   command;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_res;
  logic         m_c;
  logic         m_z;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .A         (A),
    .B         (B),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: operate on plain integers, then reduce to WIDTH bits and flags.
  function automatic void model(input int c, input int a, input int b, input int cin,
                                output logic [W-1:0] r, output logic co, output logic z);
    int lim;
    int full;
    lim = 1 << W;
    full = 0;
    co = 1'b0;
    z = 1'b0;
    case (c)
      0: r = W'(a);
      1: begin full = a - b; r = W'((full + lim) % lim); co = (a < b); z = (a == b); end
      2: r = W'(b);
      3: begin full = a + b; r = W'(full % lim); co = (full >= lim); z = (full == 0); end
      4: r = W'((lim - 1) - (a & b));
      5: begin full = a + b + cin; r = W'(full % lim); co = (full >= lim); z = (full == 0); end
      6: r = W'(a ^ b);
      default: begin full = a * b; r = W'(full % lim); co = (full >= lim); z = (full == 0); end
    endcase
  endfunction

  // Issue one command at a negedge and check its completion; during a multiply
  // random traffic is thrown at the inputs and must be ignored.
  task automatic run_op(input int c, input int a, input int b, input string tag);
    logic [W-1:0] er;
    logic ec, ez;
    model(c, a, b, int'(m_c), er, ec, ez);
    command  = 3'(c);
    A        = W'(a);
    B        = W'(b);
    in_valid = 1'b1;
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    if (c == 7) begin
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        in_valid = 1'($urandom_range(0, 1));
        command  = 3'($urandom);
        A        = W'($urandom);
        B        = W'($urandom);
        check({tag, ".busy"}, 32'(in_ready), 32'd0);
        check({tag, ".novld"}, 32'(out_valid), 32'd0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    command  = 3'($urandom);
    A        = W'($urandom);
    B        = W'($urandom);
    check({tag, ".vld"}, 32'(out_valid), 32'd1);
    check({tag, ".res"}, 32'(result), 32'(er));
    check({tag, ".carry"}, 32'(carry), 32'(ec));
    check({tag, ".zero"}, 32'(zero), 32'(ez));
    m_res = er;
    m_c   = ec;
    m_z   = ez;
  endtask

  // One idle cycle: no pulse, outputs hold.
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, ".idle_vld"}, 32'(out_valid), 32'd0);
    check({tag, ".hold_res"}, 32'(result), 32'(m_res));
    check({tag, ".hold_c"}, 32'(carry), 32'(m_c));
    check({tag, ".hold_z"}, 32'(zero), 32'(m_z));
  endtask

  initial begin
    // Reset with a command presented: it must be ignored.
    reset    = 1'b1;
    in_valid = 1'b1;
    command  = 3'b011;
    A        = 4'b0111;
    B        = 4'b1001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst.res", 32'(result), 32'd0);
    check("rst.carry", 32'(carry), 32'd0);
    check("rst.zero", 32'(zero), 32'd0);
    check("rst.vld", 32'(out_valid), 32'd0);
    check("rst.ready", 32'(in_ready), 32'd1);
    m_res = '0; m_c = 1'b0; m_z = 1'b0;

    // Add with carry-out, then add-with-carry consuming it, back-to-back.
    run_op(3, 4'b0111, 4'b1001, "add");
    check("add.res_const", 32'(result), 32'h0);
    check("add.c_const", 32'(carry), 32'd1);
    run_op(5, 4'b0001, 4'b0001, "adc");
    check("adc.res_const", 32'(result), 32'h3);
    check("adc.c_const", 32'(carry), 32'd0);
    idle_check("after_adc");

    // Compare: borrow case, then equal operands.
    run_op(1, 4'b0011, 4'b0101, "cmp_lt");
    check("cmp_lt.res_const", 32'(result), 32'hE);
    run_op(1, 4'b1010, 4'b1010, "cmp_eq");
    check("cmp_eq.z_const", 32'(zero), 32'd1);

    // Pass A of zero: flags forced low even though the value is zero.
    run_op(0, 4'b0000, 4'b1111, "passa0");
    check("passa0.z_const", 32'(zero), 32'd0);
    idle_check("after_pass");

    // Multiply 15*15 with ignored traffic during MUL.
    run_op(7, 4'b1111, 4'b1111, "mul15");
    check("mul15.res_const", 32'(result), 32'h1);
    check("mul15.c_const", 32'(carry), 32'd1);
    idle_check("after_mul");
    idle_check("after_mul2");

    // Reset in the second multiply cycle aborts it.
    command  = 3'b111;
    A        = 4'b1011;
    B        = 4'b0110;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_res = '0; m_c = 1'b0; m_z = 1'b0;
    check("mulrst.ready", 32'(in_ready), 32'd1);
    check("mulrst.res", 32'(result), 32'd0);
    check("mulrst.carry", 32'(carry), 32'd0);
    check("mulrst.zero", 32'(zero), 32'd0);
    check("mulrst.vld", 32'(out_valid), 32'd0);
    for (int i = 0; i < W + 1; i++) idle_check("mulrst_wait");

    // Randomized commands, mostly back-to-back with occasional gaps.
    for (int n = 0; n < 60; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), "rand");
      if ($urandom_range(0, 3) == 0) idle_check("rand_gap");
    end
    idle_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
